tohost_wb_bridge: RTL and testbench

//  Sits between the potato core's tohost mailbox and the pwm Wishbone slave.
//  - Captures each new tohost word into a small FIFO.
//  - Replays each word as a single Wishbone write: adr = word[15:0], data = word[31:16].
//  - Bus timeout, sticky FIFO overflow flag and a timeout counter, for debug LEDs.

---
 rtl/tohost_wb_bridge.sv | 157 +++++++++++++++
 tb/tb_tohost_wb_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tohost_wb_bridge.sv
// tohost_wb_bridge
//  Bridges the core's tohost mailbox to a Wishbone slave. Each new mailbox word
//  (rising edge of tohost_updated) is queued in a small FIFO. Each queued word
//  is then replayed as one Wishbone write with adr = word[15:0] and
//  data = word[31:16]. A write with no ack is abandoned after TIMEOUT cycles.
//  Debug outputs: FIFO level, sticky overflow flag and a saturating count of
//  abandoned writes.
// Ports
//  clk, btnCpuReset            clock, asynchronous active-low reset
//  tohost_data/tohost_updated  mailbox word and update level
//  o_wb_cyc/stb/we/adr/data    Wishbone master write request
//  i_wb_ack                    Wishbone slave acknowledge
//  fifo_level                  entries currently queued
//  overflow                    sticky: a word was dropped on a full FIFO
//  timeout_cnt                 saturating count of abandoned writes
//  busy                        high while a Wishbone write is outstanding
module tohost_wb_bridge #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          btnCpuReset,
  input  logic [31:0]                   tohost_data,
  input  logic                          tohost_updated,
  output logic                          o_wb_cyc,
  output logic                          o_wb_stb,
  output logic                          o_wb_we,
  output logic [15:0]                   o_wb_adr,
  output logic [15:0]                   o_wb_data,
  input  logic                          i_wb_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    timeout_cnt,
  output logic                          busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t        r_state;
  logic          r_upd_q;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;
  logic          r_cyc;
  logic          r_stb;
  logic          r_we;
  logic [15:0]   r_adr;
  logic [15:0]   r_data;
  logic [7:0]    r_timer;
  logic [7:0]    r_timeout_cnt;
  logic          r_busy;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_wr_en;
  logic [31:0]   w_head;

  // A pop frees a slot on the same edge, so a push into a full FIFO is still
  // accepted when the FSM is popping.
  assign w_push  = tohost_updated & ~r_upd_q;
  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_pop   = (r_state == S_IDLE) && (r_level != '0);
  assign w_wr_en = w_push & (~w_full | w_pop);
  assign w_head  = r_mem[r_rd_ptr];

  // Edge detect, FIFO pointers, level and sticky overflow.
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      r_upd_q    <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_upd_q <= tohost_updated;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= tohost_data;
  end

  // Wishbone request FSM; ack has priority over the timeout on the same edge.
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      r_state       <= S_IDLE;
      r_cyc         <= 1'b0;
      r_stb         <= 1'b0;
      r_we          <= 1'b0;
      r_adr         <= '0;
      r_data        <= '0;
      r_timer       <= '0;
      r_timeout_cnt <= '0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_adr   <= w_head[15:0];
            r_data  <= w_head[31:16];
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= 1'b1;
            r_busy  <= 1'b1;
            r_timer <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_wb_ack) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_timer == 8'(TIMEOUT - 1)) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            if (r_timeout_cnt != 8'hFF) r_timeout_cnt <= r_timeout_cnt + 8'd1;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wb_cyc    = r_cyc;
  assign o_wb_stb    = r_stb;
  assign o_wb_we     = r_we;
  assign o_wb_adr    = r_adr;
  assign o_wb_data   = r_data;
  assign fifo_level  = r_level;
  assign overflow    = r_overflow;
  assign timeout_cnt = r_timeout_cnt;
  assign busy        = r_busy;

endmodule

// File: tb/tb_tohost_wb_bridge.sv
// tb_tohost_wb_bridge
//  Self-checking bench. u_dut (TIMEOUT=8) is compared every cycle against a
//  queue-based reference model. u_big (TIMEOUT=255) shares the mailbox inputs
//  and is used for the directed fill/overflow and full-FIFO push/pop cases.
module tb_tohost_wb_bridge;

  localparam int unsigned DEPTH = 4;
  localparam int          TO    = 8;

  logic        clk;
  logic        btnCpuReset;
  logic [31:0] tohost_data;
  logic        tohost_updated;
  logic        ack;
  logic        ack_big;

  logic        cyc, stb, we, ovf, bsy;
  logic [15:0] adr, wdat;
  logic [2:0]  lvl;
  logic [7:0]  tocnt;

  logic        cyc_b, stb_b, we_b, ovf_b, bsy_b;
  logic [15:0] adr_b, wdat_b;
  logic [2:0]  lvl_b;
  logic [7:0]  tocnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_q[$];
  bit          m_busy;
  logic [15:0] m_adr, m_data;
  int          m_elapsed;
  int          m_tocnt;
  bit          m_ovf;
  bit          m_prev_upd;

  logic [31:0] wr_log[$];
  logic [31:0] wr_log_b[$];
  logic [31:0] words[6];

  tohost_wb_bridge #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) u_dut (
    .clk(clk), .btnCpuReset(btnCpuReset), .tohost_data(tohost_data),
    .tohost_updated(tohost_updated), .o_wb_cyc(cyc), .o_wb_stb(stb),
    .o_wb_we(we), .o_wb_adr(adr), .o_wb_data(wdat), .i_wb_ack(ack),
    .fifo_level(lvl), .overflow(ovf), .timeout_cnt(tocnt), .busy(bsy)
  );

  tohost_wb_bridge #(.FIFO_DEPTH(DEPTH), .TIMEOUT(255)) u_big (
    .clk(clk), .btnCpuReset(btnCpuReset), .tohost_data(tohost_data),
    .tohost_updated(tohost_updated), .o_wb_cyc(cyc_b), .o_wb_stb(stb_b),
    .o_wb_we(we_b), .o_wb_adr(adr_b), .o_wb_data(wdat_b), .i_wb_ack(ack_big),
    .fifo_level(lvl_b), .overflow(ovf_b), .timeout_cnt(tocnt_b), .busy(bsy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy     = 1'b0;
    m_adr      = '0;
    m_data     = '0;
    m_elapsed  = 0;
    m_tocnt    = 0;
    m_ovf      = 1'b0;
    m_prev_upd = 1'b0;
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_step();
    bit          pushed;
    logic [31:0] w;
    pushed = tohost_updated && !m_prev_upd;
    if (m_busy) begin
      if (ack) m_busy = 1'b0;
      else if (m_elapsed == TO) begin
        m_busy = 1'b0;
        if (m_tocnt < 255) m_tocnt++;
      end else m_elapsed++;
    end else if (m_q.size() > 0) begin
      w         = m_q.pop_front();
      m_busy    = 1'b1;
      m_adr     = w[15:0];
      m_data    = w[31:16];
      m_elapsed = 1;
    end
    if (pushed) begin
      if (m_q.size() < int'(DEPTH)) m_q.push_back(tohost_data);
      else m_ovf = 1'b1;
    end
    m_prev_upd = tohost_updated;
  endtask

  task automatic compare_all();
    chk("stb",     32'(stb),  32'(m_busy));
    chk("cyc",     32'(cyc),  32'(m_busy));
    chk("we",      32'(we),   32'(m_busy));
    chk("busy",    32'(bsy),  32'(m_busy));
    chk("level",   32'(lvl),  32'(m_q.size()));
    chk("ovf",     32'(ovf),  32'(m_ovf));
    chk("tocnt",   32'(tocnt), 32'(m_tocnt));
    if (m_busy) begin
      chk("adr",  32'(adr),  32'(m_adr));
      chk("data", 32'(wdat), 32'(m_data));
    end
  endtask

  task automatic tick();
    if (stb && ack)       wr_log.push_back({wdat, adr});
    if (stb_b && ack_big) wr_log_b.push_back({wdat_b, adr_b});
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    btnCpuReset    = 1'b0;
    tohost_updated = 1'b0;
    ack            = 1'b0;
    ack_big        = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_adr",  32'(adr),  32'h0);
    chk("rst_data", 32'(wdat), 32'h0);
    chk("rst_big_stb", 32'(stb_b), 32'h0);
    chk("rst_big_lvl", 32'(lvl_b), 32'h0);
    @(posedge clk);
    @(negedge clk);
    btnCpuReset = 1'b1;
    wr_log.delete();
    wr_log_b.delete();
  endtask

  task automatic pulse(input logic [31:0] w);
    tohost_data    = w;
    tohost_updated = 1'b1;
    tick();
    tohost_updated = 1'b0;
    tick();
  endtask

  initial begin
    int cnt;
    btnCpuReset    = 1'b0;
    tohost_data    = '0;
    tohost_updated = 1'b0;
    ack            = 1'b0;
    ack_big        = 1'b0;
    #3;

    // Single write with ack on the third strobe cycle
    do_reset();
    tohost_data    = 32'hABCD0012;
    tohost_updated = 1'b1;
    tick();
    chk("t1_stb_at_push", 32'(stb), 32'h0);
    tohost_updated = 1'b0;
    tick();
    chk("t1_stb_up",  32'(stb),  32'h1);
    chk("t1_adr",     32'(adr),  32'h0012);
    chk("t1_data",    32'(wdat), 32'hABCD);
    chk("t1_we",      32'(we),   32'h1);
    tick();
    tick();
    ack = 1'b1;
    tick();
    chk("t1_stb_down", 32'(stb), 32'h0);
    ack = 1'b0;
    tick();
    chk("t1_nwrites", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() > 0) chk("t1_word", wr_log[0], 32'hABCD0012);

    // Level held high for ten cycles gives one write
    do_reset();
    ack            = 1'b1;
    tohost_data    = 32'h55AA1234;
    tohost_updated = 1'b1;
    repeat (10) tick();
    tohost_updated = 1'b0;
    repeat (20) tick();
    chk("t4_nwrites", 32'(wr_log.size()), 32'd1);
    ack = 1'b0;

    // Timeout length and counter saturation
    do_reset();
    pulse(32'h0BAD0001);
    cnt = (stb === 1'b1) ? 1 : 0;
    repeat (20) begin
      tick();
      if (stb === 1'b1) cnt++;
    end
    chk("t3_stb_cycles", 32'(cnt),   32'd8);
    chk("t3_tocnt1",     32'(tocnt), 32'd1);
    chk("t3_drained",    32'(lvl),   32'd0);
    repeat (2800) begin
      tohost_data    = $urandom;
      tohost_updated = ~tohost_updated;
      tick();
    end
    tohost_updated = 1'b0;
    chk("t3_tocnt_sat", 32'(tocnt), 32'd255);

    // Fill with no ack: first word in flight, four stored, sixth dropped
    do_reset();
    for (int i = 0; i < 6; i++) begin
      words[i] = {16'(i + 16'h1100), 16'($urandom)};
      pulse(words[i]);
    end
    chk("t2_level", 32'(lvl_b), 32'd4);
    chk("t2_ovf",   32'(ovf_b), 32'd1);
    chk("t2_stb",   32'(stb_b), 32'd1);
    chk("t2_adr",   32'(adr_b), 32'(words[0][15:0]));

    // Asynchronous reset while a request is outstanding
    @(posedge clk);
    #3;
    btnCpuReset = 1'b0;
    #1;
    chk("t5_stb",   32'(stb_b), 32'h0);
    chk("t5_cyc",   32'(cyc_b), 32'h0);
    chk("t5_busy",  32'(bsy_b), 32'h0);
    chk("t5_level", 32'(lvl_b), 32'h0);
    chk("t5_ovf",   32'(ovf_b), 32'h0);
    model_reset();
    compare_all();
    @(negedge clk);
    btnCpuReset = 1'b1;
    cnt = 0;
    repeat (20) begin
      tick();
      if (stb_b === 1'b1) cnt++;
    end
    chk("t5_no_stray", 32'(cnt), 32'd0);

    // Push on the same edge the idle FSM pops from a full FIFO
    do_reset();
    for (int i = 0; i < 5; i++) begin
      words[i] = {16'(i + 16'h2200), 16'($urandom)};
      pulse(words[i]);
    end
    chk("t6_full", 32'(lvl_b), 32'd4);
    ack_big = 1'b1;
    tick();
    ack_big        = 1'b0;
    words[5]       = 32'h7777BEEF;
    tohost_data    = words[5];
    tohost_updated = 1'b1;
    tick();
    chk("t6_level", 32'(lvl_b), 32'd4);
    chk("t6_ovf",   32'(ovf_b), 32'd0);
    chk("t6_adr",   32'(adr_b), 32'(words[1][15:0]));
    tohost_updated = 1'b0;
    ack_big        = 1'b1;
    repeat (30) tick();
    ack_big = 1'b0;
    chk("t6_nwrites", 32'(wr_log_b.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < wr_log_b.size()) chk($sformatf("t6_order%0d", i), wr_log_b[i], words[i]);

    // Random traffic against the model
    do_reset();
    repeat (1500) begin
      tohost_data    = $urandom;
      tohost_updated = 1'($urandom_range(0, 1));
      ack            = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
